// File: rtl/cpu.sv
// Single-cycle RV32I core with a two-cycle load path through a registered data RAM.
// Optional macro CPU_REGFILE_RESET_EN: reset also clears the register file.
module cpu (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    output logic [31:0] data_addr,
    input  logic [31:0] data_rd,
    output logic [31:0] data_wr,
    output logic [3:0]  data_wr_en
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc;
    logic        ld_wait;
    logic [31:0] rf [0:31];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] ea;

    logic [31:0] next_pc;
    logic        wait_next;
    logic        wb_en;
    logic [31:0] wb_val;
    logic [3:0]  wr_en;
    logic [31:0] wr_data;
    logic [31:0] alu_b, alu_out;
    logic [4:0]  shamt;
    logic        taken;
    logic [31:0] ld_byte, ld_half;

    assign opcode = inst_data[6:0];
    assign rd     = inst_data[11:7];
    assign funct3 = inst_data[14:12];
    assign rs1    = inst_data[19:15];
    assign rs2    = inst_data[24:20];
    assign alt    = inst_data[30];

    assign imm_i = {{20{inst_data[31]}}, inst_data[31:20]};
    assign imm_s = {{20{inst_data[31]}}, inst_data[31:25], inst_data[11:7]};
    assign imm_b = {{19{inst_data[31]}}, inst_data[31], inst_data[7],
                    inst_data[30:25], inst_data[11:8], 1'b0};
    assign imm_u = {inst_data[31:12], 12'b0};
    assign imm_j = {{11{inst_data[31]}}, inst_data[31], inst_data[19:12],
                    inst_data[20], inst_data[30:21], 1'b0};

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

    assign ea        = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign data_addr = {2'b00, ea[31:2]};
    assign inst_addr = pc;

    assign ld_byte = data_rd >> {ea[1:0], 3'b000};
    assign ld_half = data_rd >> {ea[1], 4'b0000};

    // Shared ALU for register-register and register-immediate forms
    always_comb begin
        alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;
        shamt   = alu_b[4:0];
        alu_out = 32'd0;
        case (funct3)
            3'b000:  alu_out = (opcode == OP_REG && alt) ? rs1_val - alu_b
                                                         : rs1_val + alu_b;
            3'b001:  alu_out = rs1_val << shamt;
            3'b010:  alu_out = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_out = {31'd0, rs1_val < alu_b};
            3'b100:  alu_out = rs1_val ^ alu_b;
            3'b101:  alu_out = alt ? 32'($signed(rs1_val) >>> shamt)
                                   : rs1_val >> shamt;
            3'b110:  alu_out = rs1_val | alu_b;
            default: alu_out = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = rs1_val == rs2_val;
            3'b001:  taken = rs1_val != rs2_val;
            3'b100:  taken = $signed(rs1_val) < $signed(rs2_val);
            3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  taken = rs1_val < rs2_val;
            3'b111:  taken = rs1_val >= rs2_val;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_pc   = pc + 32'd4;
        wait_next = 1'b0;
        wb_en     = 1'b0;
        wb_val    = 32'd0;
        wr_en     = 4'b0000;
        wr_data   = 32'd0;
        case (opcode)
            OP_LUI: begin
                wb_en  = 1'b1;
                wb_val = imm_u;
            end
            OP_AUIPC: begin
                wb_en  = 1'b1;
                wb_val = pc + imm_u;
            end
            OP_JAL: begin
                wb_en   = 1'b1;
                wb_val  = pc + 32'd4;
                next_pc = pc + imm_j;
            end
            OP_JALR: begin
                wb_en   = 1'b1;
                wb_val  = pc + 32'd4;
                next_pc = (rs1_val + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                if (taken) next_pc = pc + imm_b;
            end
            OP_LOAD: begin
                // First cycle holds pc while the RAM read is in flight
                if (!ld_wait) begin
                    next_pc   = pc;
                    wait_next = 1'b1;
                end else begin
                    wb_en = 1'b1;
                    case (funct3)
                        3'b000:  wb_val = {{24{ld_byte[7]}}, ld_byte[7:0]};
                        3'b001:  wb_val = {{16{ld_half[15]}}, ld_half[15:0]};
                        3'b100:  wb_val = {24'd0, ld_byte[7:0]};
                        3'b101:  wb_val = {16'd0, ld_half[15:0]};
                        default: wb_val = data_rd;
                    endcase
                end
            end
            OP_STORE: begin
                case (funct3)
                    3'b000: begin
                        wr_en   = 4'b0001 << ea[1:0];
                        wr_data = {24'd0, rs2_val[7:0]} << {ea[1:0], 3'b000};
                    end
                    3'b001: begin
                        wr_en   = 4'b0011 << {ea[1], 1'b0};
                        wr_data = {16'd0, rs2_val[15:0]} << {ea[1], 4'b0000};
                    end
                    3'b010: begin
                        wr_en   = 4'b1111;
                        wr_data = rs2_val;
                    end
                    default: ;
                endcase
            end
            OP_IMM, OP_REG: begin
                wb_en  = 1'b1;
                wb_val = alu_out;
            end
            default: ;
        endcase
    end

    assign data_wr    = wr_data;
    assign data_wr_en = rst_n ? wr_en : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= 32'd0;
            ld_wait <= 1'b0;
        end else begin
            pc      <= next_pc;
            ld_wait <= wait_next;
        end
    end

`ifdef CPU_REGFILE_RESET_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (wb_en && rd != 5'd0) begin
            rf[rd] <= wb_val;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst_n && wb_en && rd != 5'd0) rf[rd] <= wb_val;
    end
`endif

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: small ROM-less driver of inst_data plus a
// registered word RAM model with byte lanes.
module tb_cpu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic [31:0] data_addr;
    logic [31:0] data_rd;
    logic [31:0] data_wr;
    logic [3:0]  data_wr_en;

    logic [31:0] mem [0:15];
    logic        pre_en = 1'b0;
    logic [31:0] pre_val = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] SW_X1  = 32'h00102023;
    localparam logic [31:0] SW_X0  = 32'h00002023;
    localparam logic [31:0] SW_X3  = 32'h00302223;
    localparam logic [31:0] SB_I   = 32'h00208023;
    localparam logic [31:0] SH_I   = 32'h00209023;
    localparam logic [31:0] SW_I   = 32'h0020a023;
    localparam logic [31:0] JAL_I  = 32'hfedff06f;
    localparam logic [31:0] BEQ_I  = 32'h00000463;
    localparam logic [31:0] BNE_I  = 32'h00001463;
    localparam logic [31:0] LB_I   = 32'h00100183;
    localparam logic [31:0] LBU_I  = 32'h00304183;
    localparam logic [31:0] LH_I   = 32'h00201183;

    cpu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_addr  (inst_addr),
        .inst_data  (inst_data),
        .data_addr  (data_addr),
        .data_rd    (data_rd),
        .data_wr    (data_wr),
        .data_wr_en (data_wr_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (data_wr_en[i])
                mem[data_addr[3:0]][8*i +: 8] <= data_wr[8*i +: 8];
        if (pre_en) mem[0] <= pre_val;
        data_rd <= mem[data_addr[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [31:0] instr);
        inst_data = instr;
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [31:0] v);
        pre_val = v;
        pre_en  = 1'b1;
        run(NOP);
        pre_en  = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] instr,
                        input logic [31:0] exp);
        logic [31:0] p;
        p = inst_addr;
        inst_data = instr;
        #1;
        chk({tag, "_addr"}, data_addr, 32'd0);
        chk({tag, "_wen"}, {28'd0, data_wr_en}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_hold"}, inst_addr, p);
        @(posedge clk);
        #1;
        chk({tag, "_pc"}, inst_addr, p + 32'd4);
        inst_data = SW_X3;
        #1;
        chk({tag, "_val"}, data_wr, exp);
        chk({tag, "_waddr"}, data_addr, 32'd1);
        run(SW_X3);
    endtask

    initial begin
        logic [31:0] saved;
        logic [31:0] sb_exp [4];
        sb_exp = '{32'hffffff01, 32'hffff01ff, 32'hff01ffff, 32'h01ffffff};

        rst_n = 1'b0;
        inst_data = SW_X1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", inst_addr, 32'd0);
        chk("rst_wen", {28'd0, data_wr_en}, 32'd0);

        rst_n = 1'b1;
        inst_data = NOP;
        #1;
        chk("nop_wen", {28'd0, data_wr_en}, 32'd0);
        run(NOP);
        chk("nop_pc", inst_addr, 32'd4);

        run(32'h03400093);
        chk("addi_pc", inst_addr, 32'd8);
        inst_data = SW_X1;
        #1;
        chk("addi_x1", data_wr, 32'h34);
        chk("sw_wen", {28'd0, data_wr_en}, 32'hf);
        run(SW_X1);
        chk("sw_mem", mem[0], 32'h34);

        run(32'h00100113);
        for (int n = 0; n < 4; n++) begin
            preset(32'hffffffff);
            run(32'h00000093 | (n << 20));
            run(SB_I);
            chk($sformatf("sb%0d", n), mem[0], sb_exp[n]);
        end

        preset(32'hffffffff);
        run(32'h00000093);
        run(SH_I);
        chk("sh0", mem[0], 32'hffff0001);
        preset(32'hffffffff);
        run(32'h00200093);
        run(SH_I);
        chk("sh2", mem[0], 32'h0001ffff);
        preset(32'hffffffff);
        run(32'h00000093);
        run(SW_I);
        chk("sw0", mem[0], 32'h00000001);

        repeat (5) run(NOP);
        saved = inst_addr;
        run(JAL_I);
        chk("jal_pc", inst_addr, saved - 32'd20);
        inst_data = SW_X0;
        #1;
        chk("x0_zero", data_wr, 32'd0);
        run(SW_X0);

        saved = inst_addr;
        run(BEQ_I);
        chk("beq_pc", inst_addr, saved + 32'd8);
        run(BNE_I);
        chk("bne_pc", inst_addr, saved + 32'd12);

        preset(32'h80ff1234);
        load("lb", LB_I, 32'h00000012);
        load("lbu", LBU_I, 32'h00000080);
        load("lh", LH_I, 32'hffff80ff);

        saved = inst_addr;
        run(LBU_I);
        chk("abort_hold", inst_addr, saved);
        rst_n = 1'b0;
        run(LBU_I);
        chk("abort_pc", inst_addr, 32'd0);
        rst_n = 1'b1;
        inst_data = SW_X3;
        #1;
        chk("abort_x3", data_wr, 32'hffff80ff);
        run(SW_X3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
